// File: rtl/mux_share_arbiter.sv
// mux_share_arbiter: two valid/ready requesters (A, B) time-share one
// scale_mux datapath. A burst-locked arbiter drives the registered mux select,
// and the chosen beat lands in a registered output stage with its own
// valid/ready. Grants end on a beat flagged last or after BURST_MAX beats, and
// hand straight over to a waiting requester without an idle cycle.

// scale_mux: the shared combinational datapath (0 selects a, 1 selects b).
module scale_mux #(
  parameter int WIDTH = 8
) (
  input  logic             sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  assign y = sel ? b : a;

endmodule

module mux_share_arbiter #(
  parameter int WIDTH     = 8,
  parameter int BURST_MAX = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  input  logic             a_last,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic             b_last,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic             sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  // Beat counter wide enough for 0..BURST_MAX-1; BURST_MAX=1 still needs a bit.
  localparam int              CNT_W    = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2
  } state_t;

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_t;

  state_t           state;
  state_t           state_nxt;
  logic             sel_nxt;
  src_t             last_served;
  src_t             last_served_nxt;
  logic [CNT_W-1:0] beat_cnt;
  logic [CNT_W-1:0] beat_cnt_nxt;

  logic [WIDTH-1:0] mux_out;
  logic             out_free;
  logic             grant_ready;
  logic             cur_valid;
  logic             cur_last;
  logic             other_valid;
  logic             xfer;
  logic             grant_end;

  // Shared datapath, steered by the registered select.
  scale_mux #(
    .WIDTH (WIDTH)
  ) u_scale_mux (
    .sel (sel),
    .a   (a_data),
    .b   (b_data),
    .y   (mux_out)
  );

  // Handshake decode: only the granted requester sees ready, and only when
  // the output register is empty or is being drained this same cycle.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    cur_valid   = 1'b0;
    cur_last    = 1'b0;
    other_valid = 1'b0;
    a_ready     = 1'b0;
    b_ready     = 1'b0;

    out_free    = ~out_valid | out_ready;
    grant_ready = out_free & ~rst;

    unique case (state)
      GNT_A: begin
        cur_valid   = a_valid;
        cur_last    = a_last;
        other_valid = b_valid;
        a_ready     = grant_ready;
      end
      GNT_B: begin
        cur_valid   = b_valid;
        cur_last    = b_last;
        other_valid = a_valid;
        b_ready     = grant_ready;
      end
      default: ;
    endcase

    xfer      = cur_valid & grant_ready;
    // last is only meaningful on a beat that actually transfers.
    grant_end = xfer & (cur_last | (beat_cnt == CNT_LAST));
  end

  // Arbitration: pick a grant from IDLE, count beats, and end or hand over
  // the grant on last / burst limit.
  always_comb begin
    state_nxt       = state;
    last_served_nxt = last_served;
    beat_cnt_nxt    = beat_cnt;

    unique case (state)
      IDLE: begin
        if (a_valid && b_valid) begin
          // Tie: the requester served less recently wins.
          state_nxt = (last_served == SRC_B) ? GNT_A : GNT_B;
        end else if (a_valid) begin
          state_nxt = GNT_A;
        end else if (b_valid) begin
          state_nxt = GNT_B;
        end
      end
      GNT_A, GNT_B: begin
        if (xfer) begin
          beat_cnt_nxt = beat_cnt + CNT_ONE;
        end
        if (grant_end) begin
          beat_cnt_nxt    = '0;
          last_served_nxt = (state == GNT_A) ? SRC_A : SRC_B;
          if (other_valid) begin
            state_nxt = (state == GNT_A) ? GNT_B : GNT_A;
          end else begin
            state_nxt = IDLE;
          end
        end
        // A granted requester that drops valid keeps the grant: the burst
        // stays locked until last or the beat limit.
      end
      default: state_nxt = IDLE;
    endcase

    // sel follows the grant on entry and keeps its last value through IDLE.
    sel_nxt = sel;
    if (state_nxt == GNT_A) begin
      sel_nxt = 1'b0;
    end else if (state_nxt == GNT_B) begin
      sel_nxt = 1'b1;
    end
  end

  // Arbiter state register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state       <= IDLE;
      sel         <= 1'b0;
      last_served <= SRC_B;
      beat_cnt    <= '0;
    end else begin
      state       <= state_nxt;
      sel         <= sel_nxt;
      last_served <= last_served_nxt;
      beat_cnt    <= beat_cnt_nxt;
    end
  end

  // Output register: load on transfer, clear valid on a pure drain, hold
  // steady while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      // NOTE: the data register is reset as well so the shared bus shows a
      // known value after reset; a beat held here at reset is discarded.
      out_data  <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= mux_out;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_share_arbiter.sv
// tb_mux_share_arbiter: directed latency/ordering checks plus randomized
// burst traffic. Expected output order comes from a transaction-level
// arbitration model; a separate monitor pops and compares every output beat.
module tb_mux_share_arbiter;

  localparam int WIDTH     = 8;
  localparam int BURST_MAX = 4;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             last;
  } beat_t;

  typedef enum int {R_ONE, R_ZERO, R_RAND} rdy_mode_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             a_valid, a_last, a_ready;
  logic             b_valid, b_last, b_ready;
  logic [WIDTH-1:0] a_data, b_data, out_data;
  logic             sel, out_valid, out_ready;

  always #5 clk = ~clk;

  mux_share_arbiter #(
    .WIDTH     (WIDTH),
    .BURST_MAX (BURST_MAX)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .a_valid   (a_valid),
    .a_last    (a_last),
    .a_data    (a_data),
    .a_ready   (a_ready),
    .b_valid   (b_valid),
    .b_last    (b_last),
    .b_data    (b_data),
    .b_ready   (b_ready),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  int               n_checks = 0;
  int               n_fail   = 0;
  beat_t            qa[$];
  beat_t            qb[$];
  logic [WIDTH-1:0] exp_q[$];
  logic             model_last_b = 1'b1;
  logic             rst_cmd      = 1'b1;
  rdy_mode_t        rdy_mode     = R_ONE;
  logic             bubbles      = 1'b0;
  logic             a_fire, b_fire;
  logic             prev_stall   = 1'b0;
  logic [WIDTH-1:0] prev_data    = '0;

  task automatic check(input string name, input int act, input int want);
    n_checks++;
    if (act != want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, want, $time);
    end
  endtask

  function automatic beat_t mk(input logic [WIDTH-1:0] d, input logic l);
    beat_t bt;
    bt.data = d;
    bt.last = l;
    return bt;
  endfunction

  // Transaction-level reference: with both producers presenting continuously,
  // grants alternate by least-recently-served, each grant taking beats until
  // a last flag or BURST_MAX beats.
  task automatic load_phase(input beat_t la[$], input beat_t lb[$]);
    int   ia;
    int   ib;
    logic pick_b;
    beat_t bt;
    ia = 0;
    ib = 0;
    foreach (la[i]) qa.push_back(la[i]);
    foreach (lb[i]) qb.push_back(lb[i]);
    while (ia < la.size() || ib < lb.size()) begin
      if (ia < la.size() && ib < lb.size()) pick_b = !model_last_b;
      else                                  pick_b = (ib < lb.size());
      for (int n = 0; n < BURST_MAX; n++) begin
        if (pick_b) begin
          if (ib >= lb.size()) break;
          bt = lb[ib];
          ib++;
        end else begin
          if (ia >= la.size()) break;
          bt = la[ia];
          ia++;
        end
        exp_q.push_back(bt.data);
        if (bt.last) break;
      end
      model_last_b = pick_b;
    end
  endtask

  // One clock: handshakes seen at the sample point complete at the edge, then
  // inputs are re-driven just after the edge; returns at the next sample point.
  task automatic tick();
    a_fire = a_valid & a_ready;
    b_fire = b_valid & b_ready;
    @(posedge clk);
    #1;
    if (a_fire && qa.size() != 0) void'(qa.pop_front());
    if (b_fire && qb.size() != 0) void'(qb.pop_front());
    rst = rst_cmd;
    if (rst_cmd) begin
      qa.delete();
      qb.delete();
      exp_q.delete();
      model_last_b = 1'b1;
    end
    // A producer may pause only while the other has nothing pending, which
    // leaves the arbitration order unchanged.
    a_valid = (qa.size() != 0) && !(bubbles && qb.size() == 0 && $urandom_range(0, 3) == 0);
    b_valid = (qb.size() != 0) && !(bubbles && qa.size() == 0 && $urandom_range(0, 3) == 0);
    if (qa.size() != 0) begin
      a_data = qa[0].data;
      a_last = qa[0].last;
    end else begin
      a_data = WIDTH'($urandom);
      a_last = 1'($urandom);
    end
    if (qb.size() != 0) begin
      b_data = qb[0].data;
      b_last = qb[0].last;
    end else begin
      b_data = WIDTH'($urandom);
      b_last = 1'($urandom);
    end
    case (rdy_mode)
      R_ONE:   out_ready = 1'b1;
      R_ZERO:  out_ready = 1'b0;
      default: out_ready = ($urandom_range(0, 9) < 7);
    endcase
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_cmd = 1'b1;
    tick();
    rst_cmd = 1'b0;
  endtask

  task automatic run_until_empty(input int budget, input string name);
    int   cnt;
    logic done;
    cnt = 0;
    while ((exp_q.size() != 0 || out_valid) && cnt < budget) begin
      tick();
      cnt++;
    end
    done = (exp_q.size() == 0) && !out_valid;
    check({name, "_drained"}, 32'(done), 1);
    if (!done) do_reset();
  endtask

  // Monitor: scoreboard pop on every output handshake, plus stall properties.
  always @(negedge clk) begin
    if (!rst) begin
      if (prev_stall) begin
        check("hold_valid", 32'(out_valid), 1);
        check("hold_data", 32'(out_data), 32'(prev_data));
      end
      if (out_valid && !out_ready) check("stall_ready", 32'(a_ready | b_ready), 0);
      if (a_ready) check("sel_with_a_ready", 32'(sel), 0);
      if (b_ready) check("sel_with_b_ready", 32'(sel), 1);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL out_data: got 0x%0h, expected no beat at %0t", out_data, $time);
        end else begin
          check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
        end
      end
    end
    prev_stall <= !rst && out_valid && !out_ready;
    prev_data  <= out_data;
  end

  initial begin
    beat_t la[$];
    beat_t lb[$];
    int    nba;
    int    nbb;
    int    len;
    int    cnt;

    // Reset with both requesters asserting.
    rst       = 1'b1;
    a_valid   = 1'b1;
    b_valid   = 1'b1;
    a_data    = 8'h5A;
    b_data    = 8'hA5;
    a_last    = 1'b1;
    b_last    = 1'b1;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_sel", 32'(sel), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_a_ready", 32'(a_ready), 0);
    check("rst_b_ready", 32'(b_ready), 0);
    rst_cmd = 1'b0;

    // A only, single last beat: grant at +1, output at +2, back to IDLE.
    la.delete();
    lb.delete();
    la.push_back(mk(8'hFF, 1'b1));
    load_phase(la, lb);
    tick();
    check("t2_idle_a_ready", 32'(a_ready), 0);
    tick();
    check("t2_grant_a_ready", 32'(a_ready), 1);
    check("t2_grant_sel", 32'(sel), 0);
    check("t2_grant_out_valid", 32'(out_valid), 0);
    tick();
    check("t2_out_valid", 32'(out_valid), 1);
    check("t2_out_data", 32'(out_data), 'hFF);
    tick();
    check("t2_after_out_valid", 32'(out_valid), 0);
    check("t2_after_a_ready", 32'(a_ready), 0);
    check("t2_after_sel", 32'(sel), 0);

    // Tie from reset: A wins, B follows A's last with no idle cycle.
    do_reset();
    la.delete();
    lb.delete();
    la.push_back(mk(8'h11, 1'b0));
    la.push_back(mk(8'h22, 1'b1));
    lb.push_back(mk(8'hAA, 1'b1));
    load_phase(la, lb);
    tick();
    check("t3_idle_ready", 32'(a_ready | b_ready), 0);
    tick();
    check("t3_first_a_ready", 32'(a_ready), 1);
    tick();
    check("t3_last_a_ready", 32'(a_ready), 1);
    check("t3_last_sel", 32'(sel), 0);
    tick();
    check("t3_handoff_sel", 32'(sel), 1);
    check("t3_handoff_b_ready", 32'(b_ready), 1);
    run_until_empty(50, "t3");

    // Burst limit: six A beats without last are cut after four for B.
    la.delete();
    lb.delete();
    for (int i = 1; i <= 6; i++) la.push_back(mk(WIDTH'(8'hA0 + i), 1'b0));
    lb.push_back(mk(8'hB1, 1'b0));
    lb.push_back(mk(8'hB2, 1'b1));
    load_phase(la, lb);
    run_until_empty(100, "t4");
    // A never sent last, so its grant stays locked even with B waiting.
    check("t4_locked_sel", 32'(sel), 0);
    check("t4_locked_a_ready", 32'(a_ready), 1);
    qb.push_back(mk(8'hBB, 1'b1));
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t4_locked_b_ready", 32'(b_ready), 0);
    end
    do_reset();

    // Backpressure: hold for three cycles, then stream at one beat per cycle.
    la.delete();
    lb.delete();
    for (int i = 1; i <= 4; i++) la.push_back(mk(WIDTH'(8'h50 + i), (i == 4)));
    load_phase(la, lb);
    rdy_mode = R_ONE;
    cnt = 0;
    while (!out_valid && cnt < 20) begin
      tick();
      cnt++;
    end
    check("t5_first_out_valid", 32'(out_valid), 1);
    rdy_mode = R_ZERO;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5_held_valid", 32'(out_valid), 1);
      check("t5_held_data", 32'(out_data), 'h52);
      check("t5_held_a_ready", 32'(a_ready), 0);
    end
    rdy_mode = R_ONE;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5_stream_beat", 32'(out_valid & out_ready), 1);
    end
    run_until_empty(50, "t5");

    // Reset in the middle of a B burst with a beat held at the output.
    la.delete();
    lb.delete();
    for (int i = 1; i <= 6; i++) lb.push_back(mk(WIDTH'(8'h60 + i), (i == 6)));
    load_phase(la, lb);
    cnt = 0;
    while (!out_valid && cnt < 20) begin
      tick();
      cnt++;
    end
    tick();
    check("t6_pre_out_valid", 32'(out_valid), 1);
    check("t6_pre_sel", 32'(sel), 1);
    do_reset();
    tick();
    check("t6_post_out_valid", 32'(out_valid), 0);
    check("t6_post_sel", 32'(sel), 0);
    check("t6_post_ready", 32'(a_ready | b_ready), 0);
    la.delete();
    lb.delete();
    lb.push_back(mk(8'h3C, 1'b1));
    load_phase(la, lb);
    tick();
    tick();
    check("t6_b_grant_ready", 32'(b_ready), 1);
    check("t6_b_grant_sel", 32'(sel), 1);
    run_until_empty(50, "t6");

    // Randomized bursts with random backpressure, pauses and resets.
    for (int ph = 0; ph < 40; ph++) begin
      la.delete();
      lb.delete();
      nba = $urandom_range(0, 3);
      nbb = $urandom_range(0, 3);
      if (nba == 0 && nbb == 0) nba = 1;
      for (int k = 0; k < nba; k++) begin
        len = $urandom_range(1, 6);
        for (int j = 0; j < len; j++) la.push_back(mk(WIDTH'($urandom), (j == len - 1)));
      end
      for (int k = 0; k < nbb; k++) begin
        len = $urandom_range(1, 6);
        for (int j = 0; j < len; j++) lb.push_back(mk(WIDTH'($urandom), (j == len - 1)));
      end
      rdy_mode = ($urandom_range(0, 1) == 1) ? R_RAND : R_ONE;
      bubbles  = 1'($urandom);
      load_phase(la, lb);
      if ($urandom_range(0, 7) == 0) begin
        repeat ($urandom_range(2, 10)) tick();
        do_reset();
      end else begin
        run_until_empty(400, "rand");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
